// File: rtl/uart_fifo_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_access_ctrl
// Purpose  : Arbitrates two producers onto one UART FIFO write port. Runs a
//            single-outstanding read engine and a drain-to-empty flush.
// Revision : 1.0  initial release
// ============================================================================
module uart_fifo_access_ctrl #(
    parameter int RD_LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr0_req_i,
    input  logic [7:0] wr0_data_i,
    output logic       wr0_gnt_o,
    input  logic       wr1_req_i,
    input  logic [7:0] wr1_data_i,
    output logic       wr1_gnt_o,
    input  logic       rd_req_i,
    output logic       rd_ack_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    input  logic       flush_req_i,
    output logic       flush_busy_o,
    output logic [7:0] fifo_wdata_o,
    output logic       fifo_wrb_o,
    output logic       fifo_rdb_o,
    input  logic [7:0] fifo_rdata_i,
    input  logic       fifo_full_i,
    input  logic       fifo_empty_i
);

    localparam int          C_LAT_W    = 3;
    localparam logic [2:0]  C_LAT_LOAD = C_LAT_W'(RD_LATENCY - 1);

    localparam logic [1:0]  C_IDLE  = 2'd0;
    localparam logic [1:0]  C_WAIT  = 2'd1;
    localparam logic [1:0]  C_FLUSH = 2'd2;

    logic [1:0]         state_q,      state_d;
    logic [C_LAT_W-1:0] lat_cnt_q,    lat_cnt_d;
    logic               rr_last_q,    rr_last_d;
    logic               rd_valid_q,   rd_valid_d;
    logic [7:0]         rd_data_q,    rd_data_d;
    logic               flush_pend_q, flush_pend_d;

    logic               w_wr_eligible;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_rd_accept;

    // ------------------------------------------------------------------------
    // Write arbiter
    // ------------------------------------------------------------------------
    assign w_wr_eligible = !rst_i && !fifo_full_i && (state_q != C_FLUSH) && !flush_pend_q;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_wr_eligible) begin
            if (wr0_req_i && wr1_req_i) begin
                // Tie goes to whichever port did not win last time.
                if (rr_last_q) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = wr0_req_i;
                w_gnt1 = wr1_req_i;
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (w_gnt0) begin
            rr_last_d = 1'b0;
        end else if (w_gnt1) begin
            rr_last_d = 1'b1;
        end
    end

    assign wr0_gnt_o    = w_gnt0;
    assign wr1_gnt_o    = w_gnt1;
    assign fifo_wrb_o   = !(w_gnt0 || w_gnt1);
    assign fifo_wdata_o = w_gnt1 ? wr1_data_i : wr0_data_i;

    // A read following a delivered byte waits one cycle past the rd_valid pulse.
    assign w_rd_accept = (state_q == C_IDLE) && rd_req_i && !fifo_empty_i &&
                         !flush_pend_q && !rd_valid_q;

    // ------------------------------------------------------------------------
    // Read / flush FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= C_IDLE;
            lat_cnt_q    <= '0;
            rr_last_q    <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            rr_last_q    <= rr_last_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read / flush FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        flush_pend_d = flush_pend_q || (flush_req_i && (state_q != C_FLUSH));

        case (state_q)
            C_IDLE: begin
                if (flush_pend_q) begin
                    state_d      = C_FLUSH;
                    flush_pend_d = 1'b0;
                end else if (w_rd_accept) begin
                    state_d   = C_WAIT;
                    lat_cnt_d = C_LAT_LOAD;
                end
            end
            C_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rd_data_d  = fifo_rdata_i;
                    rd_valid_d = 1'b1;
                    if (flush_pend_q) begin
                        state_d      = C_FLUSH;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = C_IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            C_FLUSH: begin
                if (fifo_empty_i) begin
                    state_d = C_IDLE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read / flush FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ack_o   = 1'b0;
        fifo_rdb_o = 1'b1;
        if (!rst_i) begin
            case (state_q)
                C_IDLE: begin
                    if (w_rd_accept) begin
                        rd_ack_o   = 1'b1;
                        fifo_rdb_o = 1'b0;
                    end
                end
                C_FLUSH: begin
                    fifo_rdb_o = fifo_empty_i;
                end
                default: begin
                    fifo_rdb_o = 1'b1;
                end
            endcase
        end
    end

    assign flush_busy_o = !rst_i && (flush_pend_q || (state_q == C_FLUSH));
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;

endmodule
`default_nettype wire
